// File: rtl/iob_vexriscv_ibus_axi2iob.sv
// AXI4 read-only slave to IOb master bridge for the VexRiscv instruction bus.
// Bursts are split into single-word IOb reads, one outstanding at a time.
module iob_vexriscv_ibus_axi2iob #(
    parameter int unsigned AXI_ID_W  = 1,
    parameter int unsigned AXI_LEN_W = 8,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  rst_i,

    input  logic                  axi_arvalid_i,
    output logic                  axi_arready_o,
    input  logic [ADDR_W-1:0]     axi_araddr_i,
    input  logic [AXI_ID_W-1:0]   axi_arid_i,
    input  logic [AXI_LEN_W-1:0]  axi_arlen_i,
    input  logic [2:0]            axi_arsize_i,
    input  logic [1:0]            axi_arburst_i,

    output logic                  axi_rvalid_o,
    input  logic                  axi_rready_i,
    output logic [DATA_W-1:0]     axi_rdata_o,
    output logic [AXI_ID_W-1:0]   axi_rid_o,
    output logic [1:0]            axi_rresp_o,
    output logic                  axi_rlast_o,

    output logic                  iob_avalid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic                  iob_ready_i,
    input  logic                  iob_rvalid_i,
    input  logic [DATA_W-1:0]     iob_rdata_i
);

    localparam int unsigned WIN_W = AXI_LEN_W + 3;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [AXI_ID_W-1:0]   id_q, id_d;
    logic [AXI_LEN_W-1:0]  len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [AXI_LEN_W-1:0]  beat_q, beat_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  arready_q, arready_d;
    logic                  avalid_q, avalid_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;

    logic [1:0]            size_eff_c;
    logic [ADDR_W-1:0]     step_c;
    logic [WIN_W-1:0]      win_c;
    logic [ADDR_W-1:0]     wrap_mask_c;
    logic [ADDR_W-1:0]     addr_incr_c;
    logic [ADDR_W-1:0]     addr_next_c;

    // Next beat address; sizes above a word are clamped to a 4-byte step
    always_comb begin
        size_eff_c  = (size_q > 3'd2) ? 2'd2 : size_q[1:0];
        step_c      = ADDR_W'(1) << size_eff_c;
        win_c       = (WIN_W'({1'b0, len_q}) + WIN_W'(1)) << size_eff_c;
        wrap_mask_c = ADDR_W'(win_c) - ADDR_W'(1);
        addr_incr_c = addr_q + step_c;
        case (burst_q)
            BURST_FIXED: addr_next_c = addr_q;
            BURST_WRAP:  addr_next_c = (addr_q & ~wrap_mask_c) | (addr_incr_c & wrap_mask_c);
            default:     addr_next_c = addr_incr_c;
        endcase
    end

    // FSM next state, burst bookkeeping and registered output values
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        id_d      = id_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        rdata_d   = rdata_q;
        arready_d = 1'b0;
        avalid_d  = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (arready_q && axi_arvalid_i) begin
                    addr_d  = axi_araddr_i;
                    id_d    = axi_arid_i;
                    len_d   = axi_arlen_i;
                    size_d  = axi_arsize_i;
                    burst_d = axi_arburst_i;
                    beat_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (iob_ready_i) begin
                    if (iob_rvalid_i) begin
                        rdata_d = iob_rdata_i;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (iob_rvalid_i) begin
                    rdata_d = iob_rdata_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (axi_rready_i) begin
                    if (beat_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + AXI_LEN_W'(1);
                        addr_d  = addr_next_c;
                        state_d = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        arready_d = (state_d == IDLE);
        avalid_d  = (state_d == REQ);
        rvalid_d  = (state_d == RESP);
        rlast_d   = (state_d == RESP) && (beat_d == len_d);
    end

    // State and output registers; reset wins over the clock enable
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            id_q      <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            rdata_q   <= '0;
            arready_q <= 1'b0;
            avalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else if (cke_i) begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            id_q      <= id_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            rdata_q   <= rdata_d;
            arready_q <= arready_d;
            avalid_q  <= avalid_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
        end
    end

    assign axi_arready_o = arready_q;
    assign axi_rvalid_o  = rvalid_q;
    assign axi_rdata_o   = rdata_q;
    assign axi_rid_o     = id_q;
    assign axi_rlast_o   = rlast_q;
    assign axi_rresp_o   = (rvalid_q && (size_q > 3'd2)) ? 2'b10 : 2'b00;
    assign iob_avalid_o  = avalid_q;
    assign iob_addr_o    = {addr_q[ADDR_W-1:2], 2'b00};
    assign iob_wdata_o   = '0;
    assign iob_wstrb_o   = '0;

endmodule

// File: tb/tb_iob_vexriscv_ibus_axi2iob.sv
// Self-checking bench for the AXI read to IOb bridge: directed scenarios
// plus randomized bursts against an address/data reference model.
module tb_iob_vexriscv_ibus_axi2iob;

    logic        clk_i = 1'b0;
    logic        cke_i;
    logic        rst_i;
    logic        axi_arvalid_i;
    logic        axi_arready_o;
    logic [31:0] axi_araddr_i;
    logic [0:0]  axi_arid_i;
    logic [7:0]  axi_arlen_i;
    logic [2:0]  axi_arsize_i;
    logic [1:0]  axi_arburst_i;
    logic        axi_rvalid_o;
    logic        axi_rready_i;
    logic [31:0] axi_rdata_o;
    logic [0:0]  axi_rid_o;
    logic [1:0]  axi_rresp_o;
    logic        axi_rlast_o;
    logic        iob_avalid_o;
    logic [31:0] iob_addr_o;
    logic [31:0] iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic        iob_ready_i;
    logic        iob_rvalid_i;
    logic [31:0] iob_rdata_i;

    int checks = 0;
    int errors = 0;

    iob_vexriscv_ibus_axi2iob dut (
        .clk_i         (clk_i),
        .cke_i         (cke_i),
        .rst_i         (rst_i),
        .axi_arvalid_i (axi_arvalid_i),
        .axi_arready_o (axi_arready_o),
        .axi_araddr_i  (axi_araddr_i),
        .axi_arid_i    (axi_arid_i),
        .axi_arlen_i   (axi_arlen_i),
        .axi_arsize_i  (axi_arsize_i),
        .axi_arburst_i (axi_arburst_i),
        .axi_rvalid_o  (axi_rvalid_o),
        .axi_rready_i  (axi_rready_i),
        .axi_rdata_o   (axi_rdata_o),
        .axi_rid_o     (axi_rid_o),
        .axi_rresp_o   (axi_rresp_o),
        .axi_rlast_o   (axi_rlast_o),
        .iob_avalid_o  (iob_avalid_o),
        .iob_addr_o    (iob_addr_o),
        .iob_wdata_o   (iob_wdata_o),
        .iob_wstrb_o   (iob_wstrb_o),
        .iob_ready_i   (iob_ready_i),
        .iob_rvalid_i  (iob_rvalid_i),
        .iob_rdata_i   (iob_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference: word-aligned IOb address of beat i of an AXI read burst
    function automatic logic [31:0] model_addr(input logic [31:0] a, input int len,
                                               input int size, input int burst, input int i);
        longint unsigned step, win, base, off, r, a64;
        int sz;
        sz   = (size > 2) ? 2 : size;
        a64  = 64'(a);
        step = 64'd1 << sz;
        win  = 64'(len + 1) * step;
        case (burst)
            0: r = a64;
            2: begin
                base = a64 - (a64 % win);
                off  = (a64 - base + 64'(i) * step) % win;
                r    = base + off;
            end
            default: r = a64 + 64'(i) * step;
        endcase
        return 32'(r) & 32'hFFFF_FFFC;
    endfunction

    // Present an AR request and return at the negedge after it is accepted
    task automatic send_ar(input logic [31:0] a, input logic [0:0] id, input int len,
                           input int size, input int burst);
        int t;
        axi_arvalid_i = 1'b1;
        axi_araddr_i  = a;
        axi_arid_i    = id;
        axi_arlen_i   = 8'(len);
        axi_arsize_i  = 3'(size);
        axi_arburst_i = 2'(burst);
        t = 0;
        while (axi_arready_o !== 1'b1 && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        checks++;
        if (t >= 20) begin
            errors++;
            $display("FAIL ar_timeout: arready=%b after %0d cycles, need 1", axi_arready_o, t);
        end
        @(negedge clk_i);
        axi_arvalid_i = 1'b0;
    endtask

    // Run one burst acting as IOb slave and AXI master; optionally abandon at beat abort_at
    task automatic run_burst(input logic [31:0] a, input logic [0:0] id, input int len,
                             input int size, input int burst, input int rdy_hi,
                             input int lat_lo, input int lat_hi, input int stall,
                             input int abort_at, input bit rnd_data, input logic [31:0] dbase);
        logic [31:0] ea, d;
        logic [1:0]  eresp;
        logic        elast;
        int          dr, lat;
        eresp = (size > 2) ? 2'b10 : 2'b00;
        send_ar(a, id, len, size, burst);
        checks++;
        if (iob_avalid_o !== 1'b1) begin
            errors++;
            $display("FAIL ar_to_avalid: avalid=%b, need 1", iob_avalid_o);
        end
        for (int i = 0; i <= len; i++) begin
            if (i == abort_at) return;
            ea    = model_addr(a, len, size, burst, i);
            elast = (i == len);
            checks++;
            if (iob_avalid_o !== 1'b1 || iob_addr_o !== ea || axi_rvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL iob_req beat %0d: avalid=%b addr=%h rvalid=%b, need 1 %h 0",
                         i, iob_avalid_o, iob_addr_o, axi_rvalid_o, ea);
            end
            dr = $urandom_range(rdy_hi, 0);
            repeat (dr) @(negedge clk_i);
            checks++;
            if (iob_avalid_o !== 1'b1 || iob_addr_o !== ea) begin
                errors++;
                $display("FAIL req_hold beat %0d: avalid=%b addr=%h, need 1 %h",
                         i, iob_avalid_o, iob_addr_o, ea);
            end
            lat = $urandom_range(lat_hi, lat_lo);
            d   = rnd_data ? $urandom : dbase + 32'(i);
            iob_ready_i = 1'b1;
            if (lat == 0) begin
                iob_rvalid_i = 1'b1;
                iob_rdata_i  = d;
            end
            @(negedge clk_i);
            iob_ready_i  = 1'b0;
            iob_rvalid_i = 1'b0;
            iob_rdata_i  = $urandom;
            if (lat > 0) begin
                repeat (lat - 1) @(negedge clk_i);
                checks++;
                if (iob_avalid_o !== 1'b0 || axi_rvalid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_state beat %0d: avalid=%b rvalid=%b, need 0 0",
                             i, iob_avalid_o, axi_rvalid_o);
                end
                iob_rvalid_i = 1'b1;
                iob_rdata_i  = d;
                @(negedge clk_i);
                iob_rvalid_i = 1'b0;
                iob_rdata_i  = $urandom;
            end
            checks++;
            if (axi_rvalid_o !== 1'b1 || axi_rdata_o !== d || axi_rid_o !== id ||
                axi_rresp_o !== eresp || axi_rlast_o !== elast) begin
                errors++;
                $display("FAIL r_beat %0d: v=%b data=%h id=%h resp=%b last=%b, need 1 %h %h %b %b",
                         i, axi_rvalid_o, axi_rdata_o, axi_rid_o, axi_rresp_o, axi_rlast_o,
                         d, id, eresp, elast);
            end
            for (int s = 0; s < stall; s++) begin
                if (s % 2 == 0) begin
                    iob_rvalid_i = 1'b1;
                    iob_rdata_i  = ~d;
                end
                @(negedge clk_i);
                iob_rvalid_i = 1'b0;
                checks++;
                if (axi_rvalid_o !== 1'b1 || axi_rdata_o !== d || iob_avalid_o !== 1'b0 ||
                    axi_rlast_o !== elast || axi_rresp_o !== eresp) begin
                    errors++;
                    $display("FAIL backpressure beat %0d: v=%b data=%h avalid=%b last=%b, need 1 %h 0 %b",
                             i, axi_rvalid_o, axi_rdata_o, iob_avalid_o, axi_rlast_o, d, elast);
                end
            end
            axi_rready_i = 1'b1;
            @(negedge clk_i);
            axi_rready_i = 1'b0;
            checks++;
            if (!elast) begin
                if (iob_avalid_o !== 1'b1 || axi_rvalid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL next_req beat %0d: avalid=%b rvalid=%b, need 1 0",
                             i, iob_avalid_o, axi_rvalid_o);
                end
            end else begin
                if (axi_arready_o !== 1'b1 || axi_rvalid_o !== 1'b0 || iob_avalid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_end: arready=%b rvalid=%b avalid=%b, need 1 0 0",
                             axi_arready_o, axi_rvalid_o, iob_avalid_o);
                end
            end
        end
        // A stray IOb response while idle must leave the bridge idle
        iob_rvalid_i = 1'b1;
        iob_rdata_i  = 32'hBAD1_BAD1;
        @(negedge clk_i);
        iob_rvalid_i = 1'b0;
        checks++;
        if (axi_rvalid_o !== 1'b0 || axi_arready_o !== 1'b1) begin
            errors++;
            $display("FAIL idle_stray: rvalid=%b arready=%b, need 0 1", axi_rvalid_o, axi_arready_o);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (axi_arready_o !== 1'b0 || axi_rvalid_o !== 1'b0 || axi_rlast_o !== 1'b0 ||
            axi_rresp_o !== 2'b00 || axi_rdata_o !== 32'h0 || axi_rid_o !== 1'b0 ||
            iob_avalid_o !== 1'b0 || iob_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL %s: arready=%b rvalid=%b last=%b resp=%b data=%h id=%h avalid=%b addr=%h, need all 0",
                     tag, axi_arready_o, axi_rvalid_o, axi_rlast_o, axi_rresp_o, axi_rdata_o,
                     axi_rid_o, iob_avalid_o, iob_addr_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cke_i = 1'b0;
        axi_arvalid_i = 1'b0; axi_araddr_i = '0; axi_arid_i = '0; axi_arlen_i = '0;
        axi_arsize_i = '0; axi_arburst_i = '0; axi_rready_i = 1'b0;
        iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = '0;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset_no_cke");
        checks++;
        if (iob_wdata_o !== 32'h0 || iob_wstrb_o !== 4'h0) begin
            errors++;
            $display("FAIL write_tie: wdata=%h wstrb=%h, need 0 0", iob_wdata_o, iob_wstrb_o);
        end
        cke_i = 1'b1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (axi_arready_o !== 1'b1 || axi_rvalid_o !== 1'b0 || iob_avalid_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: arready=%b rvalid=%b avalid=%b, need 1 0 0",
                     axi_arready_o, axi_rvalid_o, iob_avalid_o);
        end
    endtask

    task automatic test_single_read();
        run_burst(32'h100, 1'b0, 0, 2, 1, 0, 0, 0, 0, -1, 1'b0, 32'hDEADBEEF);
    endtask

    task automatic test_incr_burst();
        run_burst(32'h200, 1'b0, 3, 2, 1, 0, 3, 3, 0, -1, 1'b1, 32'h0);
    endtask

    task automatic test_wrap_burst();
        run_burst(32'h38, 1'b1, 3, 2, 2, 1, 0, 2, 0, -1, 1'b1, 32'h0);
    endtask

    task automatic test_backpressure();
        run_burst(32'h500, 1'b0, 1, 2, 1, 0, 0, 1, 5, -1, 1'b1, 32'h0);
    endtask

    task automatic test_error_id();
        run_burst(32'h600, 1'b1, 1, 3, 1, 0, 0, 1, 0, -1, 1'b1, 32'h0);
    endtask

    task automatic test_fixed_burst();
        run_burst(32'h707, 1'b0, 2, 1, 0, 1, 0, 1, 1, -1, 1'b1, 32'h0);
    endtask

    task automatic test_mid_burst_reset();
        run_burst(32'h400, 1'b0, 7, 2, 1, 1, 0, 2, 0, 2, 1'b1, 32'h0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_reset_outputs("mid_burst_reset");
        iob_rvalid_i = 1'b1;
        iob_rdata_i  = 32'h5A5A_5A5A;
        @(negedge clk_i);
        iob_rvalid_i = 1'b0;
        checks++;
        if (axi_arready_o !== 1'b1 || axi_rvalid_o !== 1'b0 || iob_avalid_o !== 1'b0) begin
            errors++;
            $display("FAIL late_rvalid: arready=%b rvalid=%b avalid=%b, need 1 0 0",
                     axi_arready_o, axi_rvalid_o, iob_avalid_o);
        end
        run_burst(32'h800, 1'b1, 1, 2, 1, 0, 0, 1, 0, -1, 1'b1, 32'h0);
    endtask

    task automatic test_cke_freeze();
        send_ar(32'h40, 1'b0, 0, 2, 1);
        cke_i        = 1'b0;
        iob_ready_i  = 1'b1;
        iob_rvalid_i = 1'b1;
        iob_rdata_i  = 32'h1111_1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checks++;
            if (iob_avalid_o !== 1'b1 || iob_addr_o !== 32'h40 || axi_rvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL cke_freeze: avalid=%b addr=%h rvalid=%b, need 1 00000040 0",
                         iob_avalid_o, iob_addr_o, axi_rvalid_o);
            end
        end
        cke_i       = 1'b1;
        iob_rdata_i = 32'h2222_2222;
        @(negedge clk_i);
        iob_ready_i  = 1'b0;
        iob_rvalid_i = 1'b0;
        checks++;
        if (axi_rvalid_o !== 1'b1 || axi_rdata_o !== 32'h2222_2222 || axi_rlast_o !== 1'b1) begin
            errors++;
            $display("FAIL cke_resume: rvalid=%b data=%h last=%b, need 1 22222222 1",
                     axi_rvalid_o, axi_rdata_o, axi_rlast_o);
        end
        axi_rready_i = 1'b1;
        @(negedge clk_i);
        axi_rready_i = 1'b0;
        checks++;
        if (axi_arready_o !== 1'b1 || axi_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL cke_done: arready=%b rvalid=%b, need 1 0", axi_arready_o, axi_rvalid_o);
        end
    endtask

    task automatic test_long_burst();
        run_burst(32'h1000, 1'b0, 255, 2, 1, 0, 0, 0, 0, -1, 1'b1, 32'h0);
    endtask

    task automatic test_random_bursts();
        int len, size, burst;
        for (int k = 0; k < 40; k++) begin
            burst = $urandom_range(3, 0);
            size  = $urandom_range(7, 0);
            if (burst == 2) len = (2 << $urandom_range(3, 0)) - 1;
            else            len = $urandom_range(15, 0);
            run_burst($urandom, 1'($urandom_range(1, 0)), len, size, burst, 2, 0, 3,
                      $urandom_range(2, 0), -1, 1'b1, 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_incr_burst();
        test_wrap_burst();
        test_backpressure();
        test_error_id();
        test_fixed_burst();
        test_mid_burst_reset();
        test_cke_freeze();
        test_long_burst();
        test_random_bursts();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_vexriscv_ibus_axi2iob.md
IOB_VEXRISCV_IBUS_AXI2IOB -- requirements
Module: iob_vexriscv_ibus_axi2iob

Interface
REQ-001 SHALL have parameter AXI_ID_W, default 1, AXI ID width.
REQ-002 SHALL have parameter AXI_LEN_W, default 8, burst length width.
REQ-003 SHALL have parameter ADDR_W, default 32, AXI and IOb address width.
REQ-004 SHALL have parameter DATA_W, default 32, AXI and IOb data width; only 32 is supported.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports clk_i (in, 1, clock), cke_i (in, 1, clock enable; all state frozen when low) and rst_i (in, 1, synchronous active-high reset).
REQ-007 SHALL have AXI4 read-address slave ports: axi_arvalid_i (in, 1), axi_arready_o (out, 1), axi_araddr_i (in, ADDR_W), axi_arid_i (in, AXI_ID_W), axi_arlen_i (in, AXI_LEN_W), axi_arsize_i (in, 3) and axi_arburst_i (in, 2).
REQ-008 SHALL have AXI4 read-data slave ports: axi_rvalid_o (out, 1), axi_rready_i (in, 1), axi_rdata_o (out, DATA_W), axi_rid_o (out, AXI_ID_W), axi_rresp_o (out, 2) and axi_rlast_o (out, 1).
REQ-009 SHALL have IOb master ports: iob_avalid_o (out, 1), iob_addr_o (out, ADDR_W), iob_wdata_o (out, DATA_W, tied 0), iob_wstrb_o (out, DATA_W/8, tied 0, read-only), iob_ready_i (in, 1), iob_rvalid_i (in, 1) and iob_rdata_i (in, DATA_W).

Function
REQ-010 SHALL implement FSM states IDLE, REQ, WAIT and RESP, with at most one IOb request outstanding.
REQ-011 IDLE: axi_arready_o=1. On axi_arvalid_i, SHALL capture addr, id, len, size and burst, clear the beat counter and go to REQ.
REQ-012 REQ: iob_avalid_o=1 and iob_addr_o=current addr with bits [1:0] forced to 0.
- On iob_ready_i with iob_rvalid_i in the same cycle: capture iob_rdata_i and go to RESP.
- On iob_ready_i alone: go to WAIT.
- Otherwise: hold.
REQ-013 WAIT: iob_avalid_o=0. On iob_rvalid_i, SHALL capture iob_rdata_i and go to RESP.
REQ-014 RESP: axi_rvalid_o=1, with axi_rdata_o, axi_rid_o and axi_rresp_o held stable until axi_rready_i.
REQ-015 axi_rlast_o SHALL be 1 only in RESP when beat counter == captured len.
REQ-016 On axi_rvalid_o & axi_rready_i in RESP:
- If last beat: go to IDLE.
- Otherwise: increment the beat counter, update addr per REQ-017 and go to REQ.
REQ-017 Address update SHALL depend on burst type:
- FIXED (0): addr unchanged.
- INCR (1) and reserved (3): addr + (1<<size).
- WRAP (2): addr + (1<<size), wrapping inside the aligned window of (len+1)<<size bytes.
REQ-018 axi_rresp_o SHALL be 2'b00 (OKAY), except 2'b10 (SLVERR) on every beat of a burst captured with arsize > 2; such bursts are still executed with a 4-byte step.
REQ-019 iob_rvalid_i arriving in IDLE or RESP SHALL be ignored.
REQ-020 Latency SHALL be as follows:
- arvalid accepted at cycle N: iob_avalid_o at N+1.
- Zero-wait IOb: rvalid at N+2.
- Each subsequent beat: minimum 2 cycles after the previous rready.
REQ-021 The beat counter SHALL be AXI_LEN_W bits wide; len=255 yields 256 beats without overflow of the comparison.

Reset
REQ-022 On rst_i=1 at a clock edge (regardless of cke_i), SHALL enter IDLE with all captured registers and the beat counter cleared.
REQ-023 Output values while in reset: axi_arready_o=0 during reset, then 1 in IDLE; axi_rvalid_o=0, axi_rlast_o=0, axi_rresp_o=0, axi_rdata_o=0, axi_rid_o=0, iob_avalid_o=0, iob_addr_o=0.
REQ-024 Reset mid-burst SHALL abandon the burst immediately; a late iob_rvalid_i is then discarded per REQ-019.

Verification
REQ-025 Single read: AR addr=0x100, len=0, INCR, IOb ready and rvalid same cycle with data 0xDEADBEEF -> one R beat, rdata=0xDEADBEEF, rlast=1, rresp=0.
REQ-026 INCR burst: addr=0x200, len=3, size=2, 3-cycle IOb latency -> iob_addr 0x200, 0x204, 0x208, 0x20C; rlast only on beat 4.
REQ-027 WRAP burst: addr=0x38, len=3, size=2 -> iob_addr 0x38, 0x3C, 0x30, 0x34.
REQ-028 Backpressure: hold axi_rready_i=0 for 5 cycles in RESP -> rdata stable, no new IOb request issued until the handshake.
REQ-029 Reset mid-burst: rst_i after beat 2 of len=7 -> next cycle in IDLE with rvalid=0 and avalid=0; a new AR is accepted and starts at its own address.
REQ-030 Error and ID: arsize=3, arid=1, len=1 -> two beats with rresp=2'b10, rid=1, addresses stepped by 4.
